// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and a configurable frame format.
// Define UART_TX_PARITY_EN to add the parity ports and the PARITY state.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
`endif
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready_o   = (level_q != LVL_FULL);
  assign empty        = (level_q == '0);
  assign push         = tx_valid_i && tx_ready_o;
  assign head         = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  // Serialiser
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 load, last;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
`endif

  assign last   = (cnt_q == '0);
  assign busy_o = (state_q != S_IDLE);
  assign tx_o   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          bit_d   = '0;
          cnt_d   = CNT_MAX;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_DATA: begin
        if (last) begin
          cnt_d   = CNT_MAX;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else bit_d = bit_q + BW'(1);
        end else cnt_d = cnt_q - CW'(1);
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) begin
          state_d = S_STOP;
          bit_d   = '0;
          cnt_d   = CNT_MAX;
        end else cnt_d = cnt_q - CW'(1);
      end
`endif
      S_STOP: begin
        if (last) begin
          if (bit_q == STOP_LAST) begin
            // Back-to-back: the next start bit follows the last stop cycle directly.
            if (!empty) load = 1'b1;
            else        state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
            cnt_d = CNT_MAX;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        if (!empty) load = 1'b1;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      state_d = S_START;
      cnt_d   = CNT_MAX;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = parity_en_i;
      par_bit_d = (^head) ^ parity_odd_i;
`endif
    end

    // Line level is registered, so it follows the state being entered.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a per-cycle line/FIFO model plus a
// directed 5N2 frame on a second instance.
module tb_uart_tx_fifo;
  localparam int CPB = 16, DB = 8, SB = 1, DEPTH = 4, R = 1024;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, busy;
  logic [2:0] level;
  logic       par_en, par_odd;

  logic [4:0] d5_data;
  logic       d5_valid, d5_ready, d5_tx, d5_busy;
  logic [2:0] d5_level;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_en_i(par_en), .parity_odd_i(par_odd),
`endif
    .tx_o(tx), .busy_o(busy), .fifo_level_o(level));

  uart_tx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut5 (
    .clk_i(clk), .reset_i(rst), .tx_data_i(d5_data), .tx_valid_i(d5_valid), .tx_ready_o(d5_ready),
`ifdef UART_TX_PARITY_EN
    .parity_en_i(1'b0), .parity_odd_i(1'b0),
`endif
    .tx_o(d5_tx), .busy_o(d5_busy), .fifo_level_o(d5_level));

  int         n_vec = 0, n_err = 0;
  int         cyc = 0;
  int         next_free = 0;
  logic       ring [R];
  logic [7:0] q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Lay one frame onto the expected line starting at cycle s.
  task automatic fill(input int s, input logic [7:0] w, input logic pe, input logic po, output int len);
    logic b [$];
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(w[i]);
    if (pe) b.push_back((^w) ^ po);
    for (int i = 0; i < SB; i++) b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++)
      for (int c = 0; c < CPB; c++) ring[(s + j*CPB + c) % R] = b[j];
    len = b.size() * CPB;
  endtask

  // Check cycle cyc against the model, then apply inputs for the next edge.
  task automatic step(input logic v, input logic [7:0] d);
    logic       rdy, pe, po;
    logic [7:0] w;
    int         len;
    chk("tx",    32'(tx),       32'(ring[cyc % R]));
    ring[cyc % R] = 1'b1;
    chk("busy",  32'(busy),     32'(cyc < next_free));
    chk("level", 32'(level),    32'(q.size()));
    chk("ready", 32'(tx_ready), 32'(q.size() < DEPTH));
    tx_valid = v;
    tx_data  = d;
    rdy = (q.size() < DEPTH);
    if (q.size() > 0 && next_free <= cyc + 1) begin
      w = q.pop_front();
`ifdef UART_TX_PARITY_EN
      pe = par_en; po = par_odd;
`else
      pe = 1'b0;   po = 1'b0;
`endif
      fill(cyc + 1, w, pe, po, len);
      next_free = cyc + 1 + len;
    end
    if (v && rdy) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (q.size() > 0 || next_free > cyc); i++) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] words [5];
    int         k;
    for (int i = 0; i < R; i++) ring[i] = 1'b1;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; par_en = 1'b0; par_odd = 1'b0;
    d5_valid = 1'b0; d5_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx),       32'd1);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_level", 32'(level),    32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;

    // Single 8N1 frame.
    step(1'b1, 8'h95);
    idle(200);

`ifdef UART_TX_PARITY_EN
    par_en = 1'b1; par_odd = 1'b0;
    step(1'b1, 8'h14);
    idle(200);
    par_odd = 1'b1;
    step(1'b1, 8'h14);
    idle(40);
    par_en = 1'b0; par_odd = 1'b0;   // mid-frame change must not affect this frame
    idle(160);
    step(1'b1, 8'h14);
    idle(200);
    par_en = 1'b1;
`endif

    // Fill the FIFO while the line is busy.
    step(1'b1, 8'h3C);
    idle(20);
    for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
    k = 0;
    for (int n = 0; n < 2000 && k < 5; n++) begin
      if (q.size() < DEPTH) begin step(1'b1, words[k]); k++; end
      else step(1'b1, words[k]);
    end
    chk("burst_all_accepted", 32'(k), 32'd5);
    drain();

    // Random traffic, with parity settings wandering mid-frame.
    for (int i = 0; i < 1500; i++) begin
`ifdef UART_TX_PARITY_EN
      if ($urandom_range(0, 31) == 0) par_en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) par_odd = 1'($urandom_range(0, 1));
`endif
      step(1'($urandom_range(0, 7) == 0), 8'($urandom));
    end
    drain();

    // Reset during the data bits of an all-zero word.
    par_en = 1'b0;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    idle(38);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx",    32'(tx),    32'd1);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    tx_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); cyc++; end
    rst = 1'b0;
    q.delete();
    next_free = 0;
    for (int i = 0; i < R; i++) ring[i] = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hA5);
    idle(200);

    // 5 data bits, 2 stop bits on the second instance.
    d5_valid = 1'b1; d5_data = 5'h1F;
    @(posedge clk);
    @(negedge clk);
    d5_valid = 1'b0;
    chk("d5_level_push", 32'(d5_level), 32'd1);
    chk("d5_tx_push",    32'(d5_tx),    32'd1);
    for (int i = 1; i <= 132; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i <= 128) begin
        chk("d5_tx",   32'(d5_tx),   32'(((i - 1) / 16) != 0));
        chk("d5_busy", 32'(d5_busy), 32'd1);
      end else begin
        chk("d5_tx_end",   32'(d5_tx),   32'd1);
        chk("d5_busy_end", 32'(d5_busy), 32'd0);
      end
      if (i == 1) chk("d5_level_pop", 32'(d5_level), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
